// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: PC register, IDLE/RUN/DONE control and branch/halt/stall handling.
// Optional retired-instruction counter enabled by defining FETCH_INSTR_COUNT_EN.
module fetch_unit #(
    parameter int PC_W       = 10,
    parameter int IW         = 9,
    parameter int START_ADDR = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            halt,
    input  logic            branch,
    input  logic            taken,
    input  logic [PC_W-1:0] target,
    input  logic            stall,
    output logic [PC_W-1:0] prog_addr,
    input  logic [IW-1:0]   prog_data,
    output logic [IW-1:0]   instr,
    output logic            instr_valid,
    output logic            done,
    output logic [15:0]     instr_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE: begin
                pc_d = START_PC;
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // halt outranks branch; stall freezes everything
                if (!stall) begin
                    if (halt) begin
                        state_d = ST_DONE;
                    end else if (branch && taken) begin
                        pc_d = target;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = START_PC;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = START_PC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= START_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign prog_addr   = pc_q;
    assign instr       = prog_data;
    assign instr_valid = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);

`ifdef FETCH_INSTR_COUNT_EN
    logic [15:0] count_q, count_d;
    logic        retire;
    logic        start_accept;

    always_comb begin
        retire       = (state_q == ST_RUN) && !stall;
        start_accept = start && (state_q != ST_RUN);
        count_d      = count_q;
        if (start_accept) begin
            count_d = '0;
        end else if (retire && (count_q != '1)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign instr_count = count_q;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default parameters).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, start, halt, branch, taken, stall;
    logic [9:0]  target;
    logic [9:0]  prog_addr;
    logic [8:0]  prog_data;
    logic [8:0]  instr;
    logic        instr_valid, done;
    logic [15:0] instr_count;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef FETCH_INSTR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    // Instruction memory model: contents derived from the address
    assign prog_data = prog_addr[8:0] ^ 9'h0A5;

    fetch_unit #(.PC_W(10), .IW(9), .START_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .branch(branch),
        .taken(taken), .target(target), .stall(stall), .prog_addr(prog_addr),
        .prog_data(prog_data), .instr(instr), .instr_valid(instr_valid),
        .done(done), .instr_count(instr_count)
    );

    function automatic logic [15:0] exp_cnt(input int n);
        return CNT_EN ? 16'(n) : 16'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; halt = 1'b1; branch = 1'b1; taken = 1'b1;
        stall = 1'b1; target = 10'h155;
        step();
        reset = 1'b0; start = 1'b0; halt = 1'b0; branch = 1'b0; taken = 1'b0;
        stall = 1'b0;
        n_cmp++; if (prog_addr !== 10'd0) begin n_bad++; $display("FAIL rst_addr got %h exp %h", prog_addr, 10'd0); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b exp 0", done); end
        n_cmp++; if (instr_count !== 16'd0) begin n_bad++; $display("FAIL rst_count got %h exp 0", instr_count); end
        step(); step();
        n_cmp++; if (prog_addr !== 10'd0 || instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL idle_hold got addr %h valid %b exp 000 0", prog_addr, instr_valid);
        end
    endtask

    task automatic test_sequence();
        start = 1'b1; stall = 1'b1;    // stall has no effect in IDLE
        step();
        start = 1'b0; stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (prog_addr !== 10'(i) || instr_valid !== 1'b1) begin
                n_bad++; $display("FAIL seq_addr%0d got %h/%b exp %h/1", i, prog_addr, instr_valid, 10'(i));
            end
            n_cmp++; if (instr !== (9'(i) ^ 9'h0A5)) begin
                n_bad++; $display("FAIL seq_instr%0d got %h exp %h", i, instr, 9'(i) ^ 9'h0A5);
            end
            if (i == 5) halt = 1'b1;
            step();
        end
        halt = 1'b0;
        n_cmp++; if (done !== 1'b1 || instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL seq_done got done %b valid %b exp 1 0", done, instr_valid);
        end
        n_cmp++; if (prog_addr !== 10'd5) begin n_bad++; $display("FAIL seq_hold got %h exp 005", prog_addr); end
        n_cmp++; if (instr_count !== exp_cnt(6)) begin n_bad++; $display("FAIL seq_count got %h exp %h", instr_count, exp_cnt(6)); end
        start = 1'b0; stall = 1'b1; step(); stall = 1'b0;
        n_cmp++; if (done !== 1'b1 || prog_addr !== 10'd5) begin
            n_bad++; $display("FAIL done_hold got done %b addr %h exp 1 005", done, prog_addr);
        end
        n_cmp++; if (instr !== (9'd5 ^ 9'h0A5)) begin n_bad++; $display("FAIL done_instr got %h exp %h", instr, 9'd5 ^ 9'h0A5); end
    endtask

    task automatic test_restart();
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (prog_addr !== 10'd0 || done !== 1'b0 || instr_valid !== 1'b1) begin
            n_bad++; $display("FAIL restart got addr %h done %b valid %b exp 000 0 1", prog_addr, done, instr_valid);
        end
        n_cmp++; if (instr_count !== 16'd0) begin n_bad++; $display("FAIL restart_count got %h exp 0", instr_count); end
    endtask

    task automatic test_branch();
        step(); step(); step();
        n_cmp++; if (prog_addr !== 10'd3) begin n_bad++; $display("FAIL br_pre got %h exp 003", prog_addr); end
        branch = 1'b1; taken = 1'b1; target = 10'h040;
        step();
        n_cmp++; if (prog_addr !== 10'h040) begin n_bad++; $display("FAIL br_taken got %h exp 040", prog_addr); end
        target = 10'h003;
        step();
        n_cmp++; if (prog_addr !== 10'h003) begin n_bad++; $display("FAIL br_back got %h exp 003", prog_addr); end
        taken = 1'b0; target = 10'h040;
        step();
        branch = 1'b0;
        n_cmp++; if (prog_addr !== 10'd4) begin n_bad++; $display("FAIL br_nottaken got %h exp 004", prog_addr); end
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (prog_addr !== 10'd5) begin n_bad++; $display("FAIL run_start_ign got %h exp 005", prog_addr); end
    endtask

    task automatic test_halt_priority();
        branch = 1'b1; taken = 1'b1; target = 10'd7;
        step();
        n_cmp++; if (prog_addr !== 10'd7) begin n_bad++; $display("FAIL hp_pre got %h exp 007", prog_addr); end
        halt = 1'b1; target = 10'h100;
        step();
        halt = 1'b0; branch = 1'b0; taken = 1'b0;
        n_cmp++; if (done !== 1'b1 || prog_addr !== 10'd7) begin
            n_bad++; $display("FAIL halt_prio got done %b addr %h exp 1 007", done, prog_addr);
        end
    endtask

    task automatic test_stall();
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        halt = 1'b1; stall = 1'b1; start = 1'b1; branch = 1'b1; taken = 1'b1; target = 10'h100;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (prog_addr !== 10'd2 || instr_valid !== 1'b1 || done !== 1'b0) begin
                n_bad++; $display("FAIL stall%0d got addr %h valid %b done %b exp 002 1 0", i, prog_addr, instr_valid, done);
            end
        end
        start = 1'b0; branch = 1'b0; taken = 1'b0;
        n_cmp++; if (instr_count !== exp_cnt(2)) begin n_bad++; $display("FAIL stall_count got %h exp %h", instr_count, exp_cnt(2)); end
        stall = 1'b0;
        step();
        halt = 1'b0;
        n_cmp++; if (done !== 1'b1 || prog_addr !== 10'd2) begin
            n_bad++; $display("FAIL stall_release got done %b addr %h exp 1 002", done, prog_addr);
        end
        n_cmp++; if (instr_count !== exp_cnt(3)) begin n_bad++; $display("FAIL stall_halt_count got %h exp %h", instr_count, exp_cnt(3)); end
    endtask

    task automatic test_wrap_and_reset();
        start = 1'b1; step(); start = 1'b0;
        branch = 1'b1; taken = 1'b1; target = 10'h3FF;
        step();
        branch = 1'b0; taken = 1'b0;
        n_cmp++; if (prog_addr !== 10'h3FF) begin n_bad++; $display("FAIL wrap_pre got %h exp 3ff", prog_addr); end
        step();
        n_cmp++; if (prog_addr !== 10'h000) begin n_bad++; $display("FAIL wrap got %h exp 000", prog_addr); end
        step();
        n_cmp++; if (instr_count !== exp_cnt(3)) begin n_bad++; $display("FAIL wrap_count got %h exp %h", instr_count, exp_cnt(3)); end
        reset = 1'b1; start = 1'b1; halt = 1'b1;
        step();
        reset = 1'b0; start = 1'b0; halt = 1'b0;
        n_cmp++; if (prog_addr !== 10'd0 || instr_valid !== 1'b0 || done !== 1'b0 || instr_count !== 16'd0) begin
            n_bad++; $display("FAIL midrun_reset got addr %h valid %b done %b count %h exp 000 0 0 0000",
                              prog_addr, instr_valid, done, instr_count);
        end
        step();
        n_cmp++; if (instr_valid !== 1'b0 || prog_addr !== 10'd0) begin
            n_bad++; $display("FAIL post_reset_idle got valid %b addr %h exp 0 000", instr_valid, prog_addr);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_restart();
        test_branch();
        test_halt_priority();
        test_stall();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
